// File: rtl/blkram_stream_fifo_if.sv
// Producer stream, consumer stream and single-port RAM signals of the block-RAM stream FIFO.
// master = FIFO controller side, slave = producer/consumer/RAM environment side.
interface blkram_stream_fifo_if #(
    parameter int unsigned AddrWidth = 17,
    parameter int unsigned DataWidth = 9
);
    logic [DataWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [AddrWidth+1:0] level;
    logic                 ram_en;
    logic                 ram_we;
    logic [AddrWidth-1:0] ram_addr;
    logic [DataWidth-1:0] ram_din;
    logic [DataWidth-1:0] ram_dout;

    modport master (
        input  in_data, in_valid, out_ready, ram_dout,
        output in_ready, out_data, out_valid, level, ram_en, ram_we, ram_addr, ram_din
    );

    modport slave (
        output in_data, in_valid, out_ready, ram_dout,
        input  in_ready, out_data, out_valid, level, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/blkram_stream_fifo.sv
// Circular-buffer stream FIFO around one single-port block RAM with 1-cycle read latency;
// writes and reads share the port, a 2-entry output buffer hides the read latency.
module blkram_stream_fifo #(
    parameter int unsigned AddrWidth = 17,
    parameter int unsigned DataWidth = 9
) (
    input  logic                 clka,
    input  logic                 reset,
    blkram_stream_fifo_if.master bus
);
    localparam int unsigned Depth = 2 ** AddrWidth;
    localparam int unsigned CntW  = AddrWidth + 1;
    localparam int unsigned LvlW  = AddrWidth + 2;

    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      ram_count_q, ram_count_d;
    logic [DataWidth-1:0] ob0_q, ob0_d;
    logic [DataWidth-1:0] ob1_q, ob1_d;
    logic [1:0]           ob_count_q, ob_count_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 prio_q, prio_d;
    logic                 out_valid_q, out_valid_d;
    logic [LvlW-1:0]      level_q, level_d;

    logic       pop_c;
    logic [1:0] ob_left_c;
    logic [2:0] credit_c;
    logic       rd_cand_c;
    logic       full_c;
    logic       in_ready_c;
    logic       wr_c;
    logic       rd_c;
    logic       contested_c;

    // Port arbitration; a read is only a candidate when the output buffer has room for its return.
    always_comb begin
        pop_c       = out_valid_q & bus.out_ready;
        ob_left_c   = ob_count_q - 2'(pop_c);
        credit_c    = 3'(ob_left_c) + 3'(rd_pend_q);
        rd_cand_c   = (ram_count_q != '0) && (credit_c < 3'd2);
        full_c      = (ram_count_q == CntW'(Depth));
        in_ready_c  = !reset && !full_c && !(rd_cand_c && prio_q);
        wr_c        = bus.in_valid && in_ready_c;
        rd_c        = rd_cand_c && !wr_c && !reset;
        contested_c = rd_cand_c && bus.in_valid && !full_c;
    end

    // Next-state: pointers, RAM occupancy, output buffer shift/fill, fairness toggle.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        ob0_d       = ob0_q;
        ob1_d       = ob1_q;
        ob_count_d  = ob_left_c;
        rd_pend_d   = rd_c;
        prio_d      = prio_q ^ contested_c;

        if (wr_c) begin
            wr_ptr_d    = wr_ptr_q + AddrWidth'(1);
            ram_count_d = ram_count_q + CntW'(1);
        end else if (rd_c) begin
            rd_ptr_d    = rd_ptr_q + AddrWidth'(1);
            ram_count_d = ram_count_q - CntW'(1);
        end

        if (pop_c) begin
            ob0_d = ob1_q;
        end

        // Returning word lands behind whatever survives this cycle's pop.
        if (rd_pend_q) begin
            if (ob_left_c == 2'd0) begin
                ob0_d = bus.ram_dout;
            end else begin
                ob1_d = bus.ram_dout;
            end
            ob_count_d = ob_left_c + 2'd1;
        end

        out_valid_d = (ob_count_d != 2'd0);
        level_d     = LvlW'(ram_count_d) + LvlW'(rd_pend_d) + LvlW'(ob_count_d);
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            ob0_q       <= '0;
            ob1_q       <= '0;
            ob_count_q  <= '0;
            rd_pend_q   <= 1'b0;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            level_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            ob0_q       <= ob0_d;
            ob1_q       <= ob1_d;
            ob_count_q  <= ob_count_d;
            rd_pend_q   <= rd_pend_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = ob0_q;
    assign bus.out_valid = out_valid_q;
    assign bus.level     = level_q;
    assign bus.ram_en    = wr_c | rd_c;
    assign bus.ram_we    = wr_c;
    assign bus.ram_addr  = wr_c ? wr_ptr_q : rd_ptr_q;
    assign bus.ram_din   = bus.in_data;
endmodule

// File: tb/tb_blkram_stream_fifo.sv
// Directed bench for blkram_stream_fifo: a 128k-deep instance for latency/streaming and a
// 16-deep instance for full, wrap, arbitration, stall and mid-operation reset.
module tb_blkram_stream_fifo;
    logic clk;
    logic rst17;
    logic rst4;
    int   n_checks;
    int   n_pass;

    blkram_stream_fifo_if #(.AddrWidth(17), .DataWidth(9)) b17 ();
    blkram_stream_fifo_if #(.AddrWidth(4),  .DataWidth(9)) b4 ();

    blkram_stream_fifo #(.AddrWidth(17), .DataWidth(9)) u_big (
        .clka  (clk),
        .reset (rst17),
        .bus   (b17)
    );

    blkram_stream_fifo #(.AddrWidth(4), .DataWidth(9)) u_small (
        .clka  (clk),
        .reset (rst4),
        .bus   (b4)
    );

    // Single-port RAMs with registered read data (valid the cycle after issue).
    logic [8:0] mem17 [0:131071];
    logic [8:0] mem4  [0:15];

    always @(posedge clk) begin
        if (b17.ram_en) begin
            if (b17.ram_we) mem17[b17.ram_addr] <= b17.ram_din;
            else            b17.ram_dout <= mem17[b17.ram_addr];
        end
        if (b4.ram_en) begin
            if (b4.ram_we) mem4[b4.ram_addr] <= b4.ram_din;
            else           b4.ram_dout <= mem4[b4.ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain4();
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (b4.level == 6'd0) break;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst17 = 1'b1;
        rst4  = 1'b1;
        b17.in_valid = 1'b1;
        b4.in_valid  = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++; if (b17.in_ready !== 1'b0) $display("FAIL reset_in_ready17: got %b want 0", b17.in_ready); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b0) $display("FAIL reset_in_ready4: got %b want 0", b4.in_ready); else n_pass++;
        n_checks++; if (b17.ram_en !== 1'b0) $display("FAIL reset_ram_en17: got %b want 0", b17.ram_en); else n_pass++;
        n_checks++; if (b4.ram_en !== 1'b0) $display("FAIL reset_ram_en4: got %b want 0", b4.ram_en); else n_pass++;
        n_checks++; if (b17.level !== 19'd0) $display("FAIL reset_level17: got %0d want 0", b17.level); else n_pass++;
        n_checks++; if (b4.out_valid !== 1'b0) $display("FAIL reset_out_valid4: got %b want 0", b4.out_valid); else n_pass++;
        next_cycle();
        rst17 = 1'b0;
        rst4  = 1'b0;
        b17.in_valid = 1'b0;
        b4.in_valid  = 1'b0;
        @(negedge clk);
        n_checks++; if (b17.in_ready !== 1'b1) $display("FAIL post_reset_in_ready17: got %b want 1", b17.in_ready); else n_pass++;
        n_checks++; if (b4.level !== 6'd0) $display("FAIL post_reset_level4: got %0d want 0", b4.level); else n_pass++;
        next_cycle();
    endtask

    // Lone word shows the 3-cycle latency, then 0x001..0x00F stream behind it.
    task automatic test_latency_stream();
        int nxt  = 1;
        int ngot = 1;
        b17.out_ready = 1'b1;
        b17.in_valid  = 1'b1;
        b17.in_data   = 9'h000;
        @(negedge clk);
        n_checks++; if (b17.in_ready !== 1'b1) $display("FAIL lat_accept: got %b want 1", b17.in_ready); else n_pass++;
        next_cycle();
        b17.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({b17.ram_en, b17.ram_we, b17.out_valid} !== 3'b100) $display("FAIL lat_read_issue: en/we/ov got %b want 100", {b17.ram_en, b17.ram_we, b17.out_valid}); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (b17.out_valid !== 1'b0) $display("FAIL lat_capture: out_valid got %b want 0", b17.out_valid); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (b17.out_valid !== 1'b1 || b17.out_data !== 9'h000) $display("FAIL lat_visible: ov %b data %h want 1 000", b17.out_valid, b17.out_data); else n_pass++;
        for (int c = 0; c < 200 && ngot < 16; c++) begin
            next_cycle();
            b17.in_valid = (nxt < 16);
            b17.in_data  = 9'(nxt);
            @(negedge clk);
            if (b17.in_valid && b17.in_ready) nxt++;
            if (b17.out_valid) begin
                n_checks++;
                if (b17.out_data !== 9'(ngot)) $display("FAIL stream_word%0d: got %h want %h", ngot, b17.out_data, 9'(ngot));
                else n_pass++;
                ngot++;
            end
        end
        n_checks++; if (ngot !== 16) $display("FAIL stream_count: got %0d want 16", ngot); else n_pass++;
        next_cycle();
        b17.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (b17.level !== 19'd0) $display("FAIL stream_level_end: got %0d want 0", b17.level); else n_pass++;
        next_cycle();
    endtask

    // 40 words with pseudo-random handshakes; checks order, level, and port addressing across wraps.
    task automatic test_random();
        logic [8:0]  q[$];
        logic [8:0]  exp_w;
        logic [3:0]  exp_a;
        logic [15:0] lfsr = 16'hACE1;
        int sent = 0, popped = 0, wa = 0, ra = 0;
        for (int c = 0; c < 2000 && popped < 40; c++) begin
            next_cycle();
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            b4.in_valid  = lfsr[0] && (sent < 40);
            b4.in_data   = 9'(sent * 11 + 3);
            b4.out_ready = lfsr[3] | lfsr[7];
            @(negedge clk);
            n_checks++;
            if (int'(b4.level) !== sent - popped || b4.level > 6'd18) $display("FAIL rand_level: got %0d want %0d", b4.level, sent - popped);
            else n_pass++;
            n_checks++;
            if ((b4.in_valid & b4.in_ready) !== (b4.ram_en & b4.ram_we)) $display("FAIL rand_write_port: en %b we %b want we %b", b4.ram_en, b4.ram_we, b4.in_valid & b4.in_ready);
            else n_pass++;
            if (b4.ram_en) begin
                exp_a = b4.ram_we ? 4'(wa) : 4'(ra);
                n_checks++;
                if (b4.ram_addr !== exp_a) $display("FAIL rand_addr: got %0d want %0d", b4.ram_addr, exp_a);
                else n_pass++;
                if (b4.ram_we) wa++;
                else ra++;
            end
            if (b4.in_valid && b4.in_ready) begin
                q.push_back(b4.in_data);
                sent++;
            end
            if (b4.out_valid && b4.out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rand_extra_word: got %h want none", b4.out_data);
                else begin
                    exp_w = q.pop_front();
                    if (b4.out_data !== exp_w) $display("FAIL rand_order: got %h want %h", b4.out_data, exp_w);
                    else n_pass++;
                end
                popped++;
            end
        end
        n_checks++; if (popped !== 40) $display("FAIL rand_count: got %0d want 40", popped); else n_pass++;
        next_cycle();
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        int acc = 0, ngot = 0;
        b4.out_ready = 1'b0;
        for (int c = 0; c < 60; c++) begin
            next_cycle();
            b4.in_valid = 1'b1;
            b4.in_data  = 9'(32'h100 + acc);
            @(negedge clk);
            if (b4.in_ready) acc++;
        end
        n_checks++; if (acc !== 18) $display("FAIL fill_accepts: got %0d want 18", acc); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", b4.in_ready); else n_pass++;
        n_checks++; if (b4.level !== 6'd18) $display("FAIL fill_level: got %0d want 18", b4.level); else n_pass++;
        next_cycle();
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        for (int c = 0; c < 60 && ngot < 18; c++) begin
            @(negedge clk);
            if (b4.out_valid) begin
                n_checks++;
                if (b4.out_data !== 9'(32'h100 + ngot)) $display("FAIL drain_word%0d: got %h want %h", ngot, b4.out_data, 9'(32'h100 + ngot));
                else n_pass++;
                ngot++;
            end
            next_cycle();
        end
        n_checks++; if (ngot !== 18) $display("FAIL drain_count: got %0d want 18", ngot); else n_pass++;
        @(negedge clk);
        n_checks++; if (b4.level !== 6'd0) $display("FAIL drain_level: got %0d want 0", b4.level); else n_pass++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int   acc = 0;
        logic prev = 1'b0;
        b4.out_ready = 1'b0;
        b4.in_valid  = 1'b1;
        for (int c = 0; c < 30 && acc < 4; c++) begin
            b4.in_data = 9'(32'h0C0 + acc);
            @(negedge clk);
            if (b4.in_ready) acc++;
            next_cycle();
        end
        b4.out_ready = 1'b1;
        repeat (10) next_cycle();
        for (int c = 0; c < 8; c++) begin
            b4.in_data = 9'(32'h0E0 + c);
            @(negedge clk);
            n_checks++;
            if (b4.ram_en !== 1'b1 || (c > 0 && b4.ram_we === prev)) $display("FAIL alternate_c%0d: en %b we %b prev_we %b", c, b4.ram_en, b4.ram_we, prev);
            else n_pass++;
            prev = b4.ram_we;
            next_cycle();
        end
        drain4();
        n_checks++; if (b4.level !== 6'd0) $display("FAIL alternate_drain: level got %0d want 0", b4.level); else n_pass++;
        next_cycle();
    endtask

    task automatic test_stall();
        int   acc  = 0;
        logic seen = 1'b0;
        b4.out_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = 9'(32'h0A5 + acc);
            @(negedge clk);
            if (b4.in_ready) acc++;
            seen = b4.out_valid;
            next_cycle();
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL stall_valid_timeout: got %b want 1", seen); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            b4.in_data = 9'(32'h0A5 + acc);
            @(negedge clk);
            if (b4.in_ready) acc++;
            n_checks++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== 9'h0A5) $display("FAIL stall_hold_c%0d: ov %b data %h want 1 0a5", c, b4.out_valid, b4.out_data);
            else n_pass++;
            next_cycle();
        end
        drain4();
        next_cycle();
    endtask

    task automatic test_mid_reset();
        int   acc  = 0;
        logic seen = 1'b0;
        b4.out_ready = 1'b0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = 9'(32'h010 + acc);
            @(negedge clk);
            if (b4.in_ready) acc++;
            next_cycle();
        end
        b4.in_valid = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        n_checks++; if (b4.level !== 6'd8) $display("FAIL mrst_preload_level: got %0d want 8", b4.level); else n_pass++;
        next_cycle();
        b4.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({b4.ram_en, b4.ram_we} !== 2'b10) $display("FAIL mrst_read_issue: en/we got %b want 10", {b4.ram_en, b4.ram_we}); else n_pass++;
        next_cycle();
        b4.out_ready = 1'b0;
        rst4         = 1'b1;
        b4.in_valid  = 1'b1;
        b4.in_data   = 9'h1FF;
        @(negedge clk);
        n_checks++; if (b4.level !== 6'd7) $display("FAIL mrst_level_before: got %0d want 7", b4.level); else n_pass++;
        n_checks++; if ({b4.in_ready, b4.ram_en} !== 2'b00) $display("FAIL mrst_blocked: in_ready/ram_en got %b want 00", {b4.in_ready, b4.ram_en}); else n_pass++;
        next_cycle();
        rst4         = 1'b0;
        b4.in_data   = 9'h1AA;
        b4.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (b4.level !== 6'd0) $display("FAIL mrst_level_after: got %0d want 0", b4.level); else n_pass++;
        n_checks++; if (b4.out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b want 0", b4.out_valid); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b1) $display("FAIL mrst_in_ready: got %b want 1", b4.in_ready); else n_pass++;
        next_cycle();
        b4.in_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = b4.out_valid;
            if (!seen) next_cycle();
        end
        n_checks++; if (seen !== 1'b1 || b4.out_data !== 9'h1AA) $display("FAIL mrst_first_word: ov %b data %h want 1 1aa", seen, b4.out_data); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++; if (b4.level !== 6'd0) $display("FAIL mrst_final_level: got %0d want 0", b4.level); else n_pass++;
        next_cycle();
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst17         = 1'b1;
        rst4          = 1'b1;
        b17.in_valid  = 1'b0;
        b17.in_data   = '0;
        b17.out_ready = 1'b0;
        b4.in_valid   = 1'b0;
        b4.in_data    = '0;
        b4.out_ready  = 1'b0;
        test_reset();
        test_latency_stream();
        test_random();
        test_fill_drain();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
